// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: shared radix-2 shift-add / restoring
// divide datapath with sign fix-up, HI/LO write strobe, stall and flush abort.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        ex_kill,
    output logic        busy,
    output logic        stall,
    output logic [1:0]  hilo_we,
    output logic [63:0] hilo_out,
    output logic        div_by_zero
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [2*W:0]    acc;
    logic [CW-1:0]   cnt;
    logic            q_sign;
    logic            r_sign;
    logic            dz_q;

    logic            is_div;
    logic            is_sgn;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic [W:0]      mul_sum;
    logic [2*W:0]    div_sh;
    logic [W:0]      div_diff;
    logic            div_ge;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;

    // One iteration of shift-add / restoring-subtract plus the final sign fix-up
    always_comb begin
        is_div   = op_q[1];
        is_sgn   = ~op_q[0];
        a_mag    = (is_sgn && a_q[W-1]) ? W'(-a_q) : a_q;
        b_mag    = (is_sgn && b_q[W-1]) ? W'(-b_q) : b_q;
        mul_sum  = acc[2*W:W] + (acc[0] ? {1'b0, a_q} : (W+1)'(0));
        div_sh   = {acc[2*W-1:0], 1'b0};
        div_diff = div_sh[2*W:W] - {1'b0, b_q};
        div_ge   = div_sh[2*W:W] >= {1'b0, b_q};
        prod_fix = q_sign ? (2*W)'(-acc[2*W-1:0]) : acc[2*W-1:0];
        quo_fix  = q_sign ? W'(-acc[W-1:0]) : acc[W-1:0];
        rem_fix  = r_sign ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            cnt      <= '0;
            q_sign   <= 1'b0;
            r_sign   <= 1'b0;
            dz_q     <= 1'b0;
            hilo_out <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= src_a;
                        b_q   <= src_b;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    q_sign <= is_sgn & (a_q[W-1] ^ b_q[W-1]);
                    r_sign <= is_sgn & a_q[W-1];
                    a_q    <= a_mag;
                    b_q    <= b_mag;
                    cnt    <= '0;
                    if (is_div && (b_q == '0)) begin
                        // HI keeps the raw dividend, LO saturates to all ones
                        hilo_out <= {a_q, {W{1'b1}}};
                        dz_q     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        dz_q  <= 1'b0;
                        acc   <= {1'b0, W'(0), (is_div ? a_mag : b_mag)};
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (is_div) begin
                        acc <= {1'b0, (div_ge ? div_diff[W-1:0] : div_sh[2*W-1:W]),
                                div_sh[W-1:1], div_ge};
                    end else begin
                        acc <= {1'b0, mul_sum, acc[W-1:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == {CW{1'b1}}) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hilo_out <= is_div ? {rem_fix, quo_fix} : prod_fix;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall drops in DONE so the instruction retires on the HI/LO commit edge
    always_comb begin
        busy        = (state != S_IDLE);
        stall       = ~flush & (((state == S_IDLE) & start) | (state == S_PREP) |
                                (state == S_ITER) | (state == S_FIX));
        hilo_we     = {2{(state == S_DONE) & ~ex_kill & ~flush}};
        div_by_zero = (state == S_DONE) & dz_q;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed, table-driven bench for muldiv_seq: per-cycle stall/strobe timing,
// results, divide-by-zero, flush abort, ex_kill and asynchronous reset.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        ex_kill = 1'b0;
    logic        busy;
    logic        stall;
    logic [1:0]  hilo_we;
    logic [63:0] hilo_out;
    logic        div_by_zero;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int NV = 14;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
        logic        dz;
        logic        kill;
    } vec_t;

    vec_t        vecs [NV];
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] last_hilo = '0;

    muldiv_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .ex_kill     (ex_kill),
        .busy        (busy),
        .stall       (stall),
        .hilo_we     (hilo_we),
        .hilo_out    (hilo_out),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after DONE
    task automatic run_op(input vec_t v);
        int done_c;
        done_c = v.dz ? 2 : 35;
        start  = 1'b1;
        op     = v.op;
        src_a  = v.a;
        src_b  = v.b;
        for (int c = 0; c <= done_c; c++) begin
            ex_kill = (c == done_c) ? v.kill : 1'b0;
            @(negedge clk);
            chk("stall", 64'(stall), 64'(c < done_c));
            chk("busy", 64'(busy), 64'(c != 0));
            if (c == done_c) begin
                chk("hilo_we_done", 64'(hilo_we), v.kill ? 64'd0 : 64'd3);
                chk("hilo_out", hilo_out, v.hilo);
                chk("div_by_zero", 64'(div_by_zero), 64'(v.dz));
            end else begin
                chk("hilo_we_idle", 64'(hilo_we), 64'd0);
                chk("dz_idle", 64'(div_by_zero), 64'd0);
            end
            @(posedge clk);
            #1;
            start   = 1'b0;
            ex_kill = 1'b0;
        end
        last_hilo = v.hilo;
    endtask

    initial begin
        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0};
        vecs[2]  = '{OP_DIVU,  32'd7,         32'd2,         64'h0000_0001_0000_0003, 1'b0, 1'b0};
        vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0};
        vecs[5]  = '{OP_DIVU,  32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, 1'b1, 1'b0};
        vecs[6]  = '{OP_MULT,  32'd7,         32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0, 1'b0};
        vecs[7]  = '{OP_DIV,   32'd100,       32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2, 1'b0, 1'b0};
        vecs[8]  = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, 1'b0, 1'b0};
        vecs[9]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF, 1'b1, 1'b0};
        vecs[10] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0};
        vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h10,        64'h0000_000F_0FFF_FFFF, 1'b0, 1'b0};
        vecs[12] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0};
        vecs[13] = '{OP_MULT,  32'd3,         32'd4,         64'h0000_0000_0000_000C, 1'b0, 1'b1};

        // Reset state
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_we", 64'(hilo_we), 64'd0);
        chk("rst_hilo", hilo_out, 64'd0);
        chk("rst_dz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back table run: each start lands in the IDLE cycle after DONE
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i]);
        end

        // Flush in cycle 10 of a DIV
        start = 1'b1;
        op    = OP_DIV;
        src_a = 32'd100;
        src_b = 32'd7;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) flush = 1'b1;
            @(negedge clk);
            chk("flush_stall", 64'(stall), (c == 10) ? 64'd0 : 64'd1);
            chk("flush_we", 64'(hilo_we), 64'd0);
            @(posedge clk);
            #1;
            start = 1'b0;
            flush = 1'b0;
        end
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hilo_kept", hilo_out, last_hilo);
        run_op('{OP_MULTU, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 1'b0, 1'b0});

        // Asynchronous reset in cycle 20 of a MULT
        start = 1'b1;
        op    = OP_MULT;
        src_a = 32'd9;
        src_b = 32'd9;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_stall", 64'(stall), 64'd0);
        chk("arst_we", 64'(hilo_we), 64'd0);
        chk("arst_hilo", hilo_out, 64'd0);
        chk("arst_dz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        run_op('{OP_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
